// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
// Holds the state encoding, the IF/ID payload layout and the bubble value.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pcplus4: 32'h0, valid: 1'b0};

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard controls and IF/ID outputs.
// master = fetch stage, slave = the surrounding pipeline / memory.
interface mips_fetch_stage_if #(
  parameter int IMEM_AW = 6
);

  logic [IMEM_AW-1:0] imem_a;
  logic [31:0]        imem_rd;
  logic               stall;
  logic               flush;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic [31:0]        pc_f;
  logic [31:0]        instr_d;
  logic [31:0]        pcplus4_d;
  logic               valid_d;
  logic               fault;

  modport master (
    output imem_a, pc_f, instr_d, pcplus4_d, valid_d, fault,
    input  imem_rd, stall, flush, redirect, redirect_pc
  );

  modport slave (
    input  imem_a, pc_f, instr_d, pcplus4_d, valid_d, fault,
    output imem_rd, stall, flush, redirect, redirect_pc
  );

endinterface

// File: rtl/mips_fetch_stage_ifid_reg.sv
// IF/ID pipeline register: one-cycle capture, clear beats enable, holds when en=0.
// Backpressure: upstream stall simply deasserts en; no internal buffering.
module ifid_reg
  import mips_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  clr,
  input  logic  en,
  input  ifid_t d,
  output ifid_t q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= IFID_BUBBLE;
    end else if (clr) begin
      q <= IFID_BUBBLE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mips_fetch_stage.sv
// Fetch stage: PC register, next-PC selection and BOOT/RUN/FAULT control; instr lands in IF/ID one cycle after its PC.
// Backpressure: stall freezes PC and IF/ID; redirect overrides stall and flush.
module mips_fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          IMEM_AW  = 6
) (
  input  logic                clk,
  input  logic                reset,
  mips_fetch_stage_if.master  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d, pc_inc;
  logic         fault_q, fault_d;
  logic         ifid_clr, ifid_en;
  ifid_t        ifid_d, ifid_q;

  assign pc_inc = pc_q + PC_STEP;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= {PC_RESET[31:2], 2'b00};
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= {pc_d[31:2], 2'b00};
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    fault_d  = fault_q;
    ifid_clr = 1'b0;
    ifid_en  = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.redirect && misaligned(bus.redirect_pc)) begin
          state_d  = FAULT;
          fault_d  = 1'b1;
          ifid_clr = 1'b1;
        end else if (bus.redirect) begin
          pc_d     = bus.redirect_pc;
          ifid_clr = 1'b1;
        end else if (bus.flush) begin
          ifid_clr = 1'b1;
          if (!bus.stall) pc_d = pc_inc;
        end else if (!bus.stall) begin
          ifid_en = 1'b1;
          pc_d    = pc_inc;
        end
      end
      FAULT: begin
        // IF/ID already holds the bubble; keep clearing so nothing can leak in.
        ifid_clr = 1'b1;
        fault_d  = 1'b1;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign ifid_d = '{instr: bus.imem_rd, pcplus4: pc_inc, valid: 1'b1};

  ifid_reg u_ifid (
    .clk   (clk),
    .reset (reset),
    .clr   (ifid_clr),
    .en    (ifid_en),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign bus.imem_a    = pc_q[IMEM_AW+1:2];
  assign bus.pc_f      = pc_q;
  assign bus.instr_d   = ifid_q.instr;
  assign bus.pcplus4_d = ifid_q.pcplus4;
  assign bus.valid_d   = ifid_q.valid;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Bench for mips_fetch_stage: directed scenarios plus random hazard traffic
// checked against a cycle-level reference model of the fetch rules.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ram [64];

  int pass_cnt  = 0;
  int check_cnt = 0;

  // reference model state
  logic [31:0] m_pc, m_instr, m_p4;
  logic        m_valid, m_fault, m_boot, m_dead;

  mips_fetch_stage_if #(.IMEM_AW(6)) bus ();

  mips_fetch_stage #(.PC_RESET(32'h0000_0000), .IMEM_AW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  assign bus.imem_rd = ram[bus.imem_a];

  always #5 clk = ~clk;

  task automatic set_in(input logic st, input logic fl, input logic rd, input logic [31:0] rpc);
    bus.stall       = st;
    bus.flush       = fl;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
  endtask

  task automatic bubble();
    m_instr = 32'h0;
    m_p4    = 32'h0;
    m_valid = 1'b0;
  endtask

  // Advance the model by one clock using the current inputs, then the DUT.
  task automatic tick();
    if (!reset) begin
      m_pc = 32'h0; bubble(); m_fault = 1'b0; m_boot = 1'b1; m_dead = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_dead) begin
      if (bus.redirect && bus.redirect_pc[1:0] != 2'b00) begin
        m_dead = 1'b1; m_fault = 1'b1; bubble();
      end else if (bus.redirect) begin
        m_pc = bus.redirect_pc; bubble();
      end else if (bus.flush) begin
        bubble();
        if (!bus.stall) m_pc = m_pc + 32'd4;
      end else if (!bus.stall) begin
        m_instr = ram[m_pc[7:2]];
        m_p4    = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    check_cnt++; if (bus.pc_f !== 32'h0) $display("FAIL reset_pc got=%h exp=0", bus.pc_f); else pass_cnt++;
    check_cnt++; if (bus.valid_d !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.valid_d); else pass_cnt++;
    check_cnt++; if (bus.instr_d !== 32'h0) $display("FAIL reset_instr got=%h exp=0", bus.instr_d); else pass_cnt++;
    check_cnt++; if (bus.pcplus4_d !== 32'h0) $display("FAIL reset_p4 got=%h exp=0", bus.pcplus4_d); else pass_cnt++;
    check_cnt++; if (bus.fault !== 1'b0) $display("FAIL reset_fault got=%b exp=0", bus.fault); else pass_cnt++;
    reset = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 32'h0000_0020);  // BOOT must ignore all of these
    tick();
    check_cnt++; if (bus.pc_f !== 32'h0) $display("FAIL boot_pc got=%h exp=0", bus.pc_f); else pass_cnt++;
    check_cnt++; if (bus.valid_d !== 1'b0) $display("FAIL boot_valid got=%b exp=0", bus.valid_d); else pass_cnt++;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_sequential();
    tick();
    check_cnt++; if (bus.pc_f !== 32'h4) $display("FAIL seq0_pc got=%h exp=4", bus.pc_f); else pass_cnt++;
    check_cnt++; if (bus.instr_d !== 32'h2008_0005) $display("FAIL seq0_instr got=%h exp=20080005", bus.instr_d); else pass_cnt++;
    check_cnt++; if (bus.pcplus4_d !== 32'h4) $display("FAIL seq0_p4 got=%h exp=4", bus.pcplus4_d); else pass_cnt++;
    check_cnt++; if (bus.valid_d !== 1'b1) $display("FAIL seq0_valid got=%b exp=1", bus.valid_d); else pass_cnt++;
    tick();
    check_cnt++; if (bus.pc_f !== 32'h8) $display("FAIL seq1_pc got=%h exp=8", bus.pc_f); else pass_cnt++;
    check_cnt++; if (bus.instr_d !== 32'h2109_0007) $display("FAIL seq1_instr got=%h exp=21090007", bus.instr_d); else pass_cnt++;
    check_cnt++; if (bus.pcplus4_d !== 32'h8) $display("FAIL seq1_p4 got=%h exp=8", bus.pcplus4_d); else pass_cnt++;
  endtask

  task automatic test_stall();
    set_in(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_cnt++; if (bus.pc_f !== 32'h8) $display("FAIL stall_pc[%0d] got=%h exp=8", i, bus.pc_f); else pass_cnt++;
      check_cnt++; if (bus.instr_d !== 32'h2109_0007 || bus.pcplus4_d !== 32'h8 || bus.valid_d !== 1'b1)
        $display("FAIL stall_ifid[%0d] got=%h/%h/%b exp=21090007/8/1", i, bus.instr_d, bus.pcplus4_d, bus.valid_d);
      else pass_cnt++;
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_cnt++; if (bus.instr_d !== ram[2]) $display("FAIL unstall_instr got=%h exp=%h", bus.instr_d, ram[2]); else pass_cnt++;
    check_cnt++; if (bus.pc_f !== 32'hC) $display("FAIL unstall_pc got=%h exp=c", bus.pc_f); else pass_cnt++;
    // get back to pc_f=8 with a live instruction in IF/ID, then stall+flush
    set_in(1'b0, 1'b0, 1'b1, 32'h4);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    check_cnt++; if (bus.valid_d !== 1'b0) $display("FAIL stallflush_valid got=%b exp=0", bus.valid_d); else pass_cnt++;
    check_cnt++; if (bus.instr_d !== 32'h0) $display("FAIL stallflush_instr got=%h exp=0", bus.instr_d); else pass_cnt++;
    check_cnt++; if (bus.pc_f !== 32'h8) $display("FAIL stallflush_pc got=%h exp=8", bus.pc_f); else pass_cnt++;
  endtask

  task automatic test_redirect_stall();
    set_in(1'b1, 1'b1, 1'b1, 32'h40);
    tick();
    check_cnt++; if (bus.pc_f !== 32'h40) $display("FAIL redir_pc got=%h exp=40", bus.pc_f); else pass_cnt++;
    check_cnt++; if (bus.imem_a !== 6'h10) $display("FAIL redir_imem_a got=%h exp=10", bus.imem_a); else pass_cnt++;
    check_cnt++; if (bus.valid_d !== 1'b0) $display("FAIL redir_valid got=%b exp=0", bus.valid_d); else pass_cnt++;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_cnt++; if (bus.instr_d !== ram[16]) $display("FAIL redir_instr got=%h exp=%h", bus.instr_d, ram[16]); else pass_cnt++;
    check_cnt++; if (bus.pcplus4_d !== 32'h44) $display("FAIL redir_p4 got=%h exp=44", bus.pcplus4_d); else pass_cnt++;
    check_cnt++; if (bus.valid_d !== 1'b1) $display("FAIL redir_valid2 got=%b exp=1", bus.valid_d); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    set_in(1'b0, 1'b0, 1'b1, 32'h42);
    tick();
    check_cnt++; if (bus.fault !== 1'b1) $display("FAIL mis_fault got=%b exp=1", bus.fault); else pass_cnt++;
    check_cnt++; if (bus.valid_d !== 1'b0) $display("FAIL mis_valid got=%b exp=0", bus.valid_d); else pass_cnt++;
    check_cnt++; if (bus.pc_f !== 32'h44) $display("FAIL mis_pc got=%h exp=44", bus.pc_f); else pass_cnt++;
    set_in(1'b0, 1'b0, 1'b1, 32'h80);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_cnt++; if (bus.pc_f !== 32'h44 || bus.fault !== 1'b1 || bus.valid_d !== 1'b0)
        $display("FAIL fault_hold[%0d] got=%h/%b/%b exp=44/1/0", i, bus.pc_f, bus.fault, bus.valid_d);
      else pass_cnt++;
    end
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    tick();
    check_cnt++; if (bus.fault !== 1'b0) $display("FAIL mis_reset_fault got=%b exp=0", bus.fault); else pass_cnt++;
    check_cnt++; if (bus.pc_f !== 32'h0) $display("FAIL mis_reset_pc got=%h exp=0", bus.pc_f); else pass_cnt++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    set_in(1'b0, 1'b0, 1'b1, 32'hFC);
    tick();
    check_cnt++; if (bus.imem_a !== 6'h3F) $display("FAIL wrap_imem_a got=%h exp=3f", bus.imem_a); else pass_cnt++;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_cnt++; if (bus.pc_f !== 32'h100) $display("FAIL alias_pc got=%h exp=100", bus.pc_f); else pass_cnt++;
    check_cnt++; if (bus.imem_a !== 6'h00) $display("FAIL alias_imem_a got=%h exp=0", bus.imem_a); else pass_cnt++;
    check_cnt++; if (bus.instr_d !== ram[63]) $display("FAIL alias_instr got=%h exp=%h", bus.instr_d, ram[63]); else pass_cnt++;
    set_in(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    check_cnt++; if (bus.pc_f !== 32'h0) $display("FAIL wrap_pc got=%h exp=0", bus.pc_f); else pass_cnt++;
    check_cnt++; if (bus.pcplus4_d !== 32'h0) $display("FAIL wrap_p4 got=%h exp=0", bus.pcplus4_d); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      reset = ($urandom_range(39) != 0);
      set_in($urandom_range(3) == 0, $urandom_range(6) == 0, $urandom_range(11) == 0, rpc);
      tick();
      check_cnt++; if (bus.pc_f !== m_pc) $display("FAIL rnd_pc[%0d] got=%h exp=%h", i, bus.pc_f, m_pc); else pass_cnt++;
      check_cnt++; if (bus.imem_a !== m_pc[7:2]) $display("FAIL rnd_imem_a[%0d] got=%h exp=%h", i, bus.imem_a, m_pc[7:2]); else pass_cnt++;
      check_cnt++; if (bus.instr_d !== m_instr) $display("FAIL rnd_instr[%0d] got=%h exp=%h", i, bus.instr_d, m_instr); else pass_cnt++;
      check_cnt++; if (bus.pcplus4_d !== m_p4) $display("FAIL rnd_p4[%0d] got=%h exp=%h", i, bus.pcplus4_d, m_p4); else pass_cnt++;
      check_cnt++; if (bus.valid_d !== m_valid) $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, bus.valid_d, m_valid); else pass_cnt++;
      check_cnt++; if (bus.fault !== m_fault) $display("FAIL rnd_fault[%0d] got=%b exp=%b", i, bus.fault, m_fault); else pass_cnt++;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = $urandom;
    ram[0] = 32'h2008_0005;
    ram[1] = 32'h2109_0007;
    m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0; m_boot = 1'b1; m_dead = 1'b0;
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
